// File: rtl/conv_pe_sched.sv
// conv_pe_sched: issue sequencer for a 3x3, 8-channel-per-cycle conv PE.
// Walks pixel -> filter -> channel group, gated by window availability and output credits.
module conv_pe_sched #(
    parameter int DIM_W       = 10,
    parameter int GRP_W       = 8,
    parameter int COUT_W      = 10,
    parameter int WADDR_W     = 18,
    parameter int RD_LAT      = 1,
    parameter int OUT_CREDITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [GRP_W-1:0]   cfg_cin_groups,
    input  logic [COUT_W-1:0]  cfg_cout,
    output logic               busy,
    output logic               done,
    input  logic               win_avail,
    output logic               win_consume,
    output logic [GRP_W-1:0]   win_grp,
    output logic [WADDR_W-1:0] wt_addr,
    output logic [COUT_W-1:0]  bias_addr,
    output logic               pe_valid_in,
    output logic               pe_last_channel,
    input  logic               pe_data_valid,
    input  logic               credit_return,
    output logic [DIM_W-1:0]   out_row,
    output logic [DIM_W-1:0]   out_col,
    output logic [COUT_W-1:0]  out_filt
);
    localparam int CW = $clog2(OUT_CREDITS + 1);
    localparam int PW = OUT_CREDITS > 1 ? $clog2(OUT_CREDITS) : 1;
    localparam int TW = 2 * DIM_W + COUT_W;

    typedef enum logic [2:0] {IDLE, WAIT_WIN, RUN, DRAIN, DONE} state_t;

    state_t              r_state;
    logic [DIM_W-1:0]    r_w, r_h, r_row, r_col;
    logic [GRP_W-1:0]    r_g, r_grp;
    logic [COUT_W-1:0]   r_c, r_filt;
    logic [WADDR_W-1:0]  r_wt_addr;
    logic [CW-1:0]       r_cred, r_inflight;
    logic [RD_LAT-1:0]   r_vsr, r_lsr;
    logic [TW-1:0]       r_tags [OUT_CREDITS];
    logic [PW-1:0]       r_wr, r_rd;

    logic w_last_grp, w_last_filt, w_last_col, w_last_row;
    logic w_issue, w_fin, w_pix, w_pop, w_ret;
    logic [PW-1:0] w_wr_nxt, w_rd_nxt;

    assign w_last_grp  = r_grp == r_g - GRP_W'(1);
    assign w_last_filt = r_filt == r_c - COUT_W'(1);
    assign w_last_col  = r_col == r_w - DIM_W'(1);
    assign w_last_row  = r_row == r_h - DIM_W'(1);
    // Only the result-producing last group needs a credit; earlier groups never stall.
    assign w_issue = r_state == RUN && (!w_last_grp || r_cred != '0);
    assign w_fin   = w_issue && w_last_grp;
    assign w_pix   = w_fin && w_last_filt;
    assign w_pop   = pe_data_valid && r_inflight != '0;
    assign w_ret   = credit_return && (r_cred != CW'(OUT_CREDITS) || w_fin);
    assign w_wr_nxt = r_wr == PW'(OUT_CREDITS - 1) ? '0 : r_wr + PW'(1);
    assign w_rd_nxt = r_rd == PW'(OUT_CREDITS - 1) ? '0 : r_rd + PW'(1);

    assign busy            = r_state inside {WAIT_WIN, RUN, DRAIN};
    assign done            = r_state == DONE;
    assign win_consume     = w_pix;
    assign win_grp         = r_grp;
    assign bias_addr       = r_filt;
    assign wt_addr         = r_wt_addr;
    assign pe_valid_in     = r_vsr[RD_LAT-1];
    assign pe_last_channel = r_lsr[RD_LAT-1];
    assign {out_row, out_col, out_filt} = r_inflight == '0 ? TW'(0) : r_tags[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_w        <= '0;
            r_h        <= '0;
            r_g        <= '0;
            r_c        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_grp      <= '0;
            r_filt     <= '0;
            r_wt_addr  <= '0;
            r_cred     <= CW'(OUT_CREDITS);
            r_inflight <= '0;
            r_vsr      <= '0;
            r_lsr      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
        end else begin
            r_vsr      <= RD_LAT'({r_vsr, w_issue});
            r_lsr      <= RD_LAT'({r_lsr, w_fin});
            r_cred     <= r_cred - CW'(w_fin) + CW'(w_ret);
            r_inflight <= r_inflight + CW'(w_fin) - CW'(w_pop);
            if (w_fin) begin
                r_tags[r_wr] <= {r_row, r_col, r_filt};
                r_wr         <= w_wr_nxt;
            end
            if (w_pop) r_rd <= w_rd_nxt;
            case (r_state)
                IDLE: if (start) begin
                    r_w       <= cfg_width;
                    r_h       <= cfg_height;
                    r_g       <= cfg_cin_groups;
                    r_c       <= cfg_cout;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_grp     <= '0;
                    r_filt    <= '0;
                    r_wt_addr <= '0;
                    r_state   <= WAIT_WIN;
                end
                WAIT_WIN: if (win_avail) r_state <= RUN;
                RUN: if (w_issue) begin
                    r_grp     <= w_last_grp ? '0 : r_grp + GRP_W'(1);
                    r_wt_addr <= w_pix ? '0 : r_wt_addr + WADDR_W'(1);
                    if (w_fin) r_filt <= w_last_filt ? '0 : r_filt + COUT_W'(1);
                    if (w_pix) begin
                        r_col   <= w_last_col ? '0 : r_col + DIM_W'(1);
                        r_row   <= !w_last_col ? r_row : w_last_row ? '0 : r_row + DIM_W'(1);
                        r_state <= w_last_col && w_last_row ? DRAIN : WAIT_WIN;
                    end
                end
                DRAIN: if (r_inflight == '0) r_state <= DONE;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv_pe_sched.md
Name: conv_pe_sched

Overview:
- Sequencer for one 3x3, 8-channel-per-cycle convolution processing element (PE).
- Walks output pixel -> output filter -> input-channel group.
- Issues window, weight and bias read addresses, plus the aligned valid_in/last_channel strobes the PE expects.
- Gates issue with window availability and a downstream output-credit pool; signals done after the last PE result has drained.

Parameters:
- DIM_W, 10, width of the row/column counters and of cfg_width/cfg_height.
- GRP_W, 8, width of the input-channel-group counter; 8 channels per group.
- COUT_W, 10, width of the filter counter.
- WADDR_W, 18, weight memory address width.
- RD_LAT, 1, read latency in cycles of the window/weight/bias memories (1..3).
- OUT_CREDITS, 8, depth of the downstream result FIFO (number of credits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a layer; ignored unless IDLE
- cfg_width  in  DIM_W  output columns, >=1
- cfg_height  in  DIM_W  output rows, >=1
- cfg_cin_groups  in  GRP_W  number of 8-channel input groups, >=1
- cfg_cout  in  COUT_W  number of filters, >=1
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the layer is complete
- win_avail  in  1  line buffer holds the window for the current pixel
- win_consume  out  1  one-cycle pulse: current pixel finished, line buffer may advance
- win_grp  out  GRP_W  channel group selected in the window read
- wt_addr  out  WADDR_W  weight read address = filter*cfg_cin_groups + group
- bias_addr  out  COUT_W  bias read address = current filter
- pe_valid_in  out  1  to PE valid_in, delayed RD_LAT cycles from issue
- pe_last_channel  out  1  to PE last_channel, delayed RD_LAT cycles from issue
- pe_data_valid  in  1  from PE data_valid
- credit_return  in  1  downstream FIFO popped one result
- out_row  out  DIM_W  row tag of the result presented alongside pe_data_valid
- out_col  out  DIM_W  column tag of that result
- out_filt  out  COUT_W  filter tag of that result

Behaviour:
- Reset values: busy=0, done=0, win_consume=0, pe_valid_in=0, pe_last_channel=0, all addresses/tags=0, credits=OUT_CREDITS, inflight=0, state IDLE.
- States:
  - IDLE: on start -> WAIT_WIN; cfg_* latched, all counters zeroed.
  - WAIT_WIN: win_avail=1 -> RUN.
  - RUN: one issue per cycle while enabled.
  - DRAIN: inflight==0 -> DONE.
  - DONE: pulse done for 1 cycle -> IDLE.
- Issue enable in RUN:
  - issue = 1 when grp != last group, or when credits > 0.
  - Issue is stalled only on a filter's last group when credits == 0.
  - No bubbles otherwise: one group per cycle.
- Counter order: grp increments fastest, then filt, then col, then row. wt_addr is incrementally tracked; no multiplier.
- On issue of the last group of a filter:
  - credits decrements and inflight increments.
  - A tag {row,col,filt} is pushed into an internal tag FIFO of depth OUT_CREDITS.
- After the last filter of a pixel:
  - win_consume pulses in the cycle of that final issue.
  - Counters advance to the next pixel. State -> WAIT_WIN, or -> DRAIN if the pixel was the final one (row=h-1, col=w-1).
  - win_avail is not sampled until the cycle after win_consume.
- pe_valid_in/pe_last_channel:
  - The issue strobe and the is-last-group flag go through an RD_LAT shift register cleared by rst.
  - pe_last_channel=1 only with pe_valid_in=1.
- pe_data_valid:
  - Pops the tag FIFO; out_* shows the head tag combinationally.
  - Decrements inflight.
  - pe_data_valid with the tag FIFO empty is a protocol error; ignore the pop.
- Credit counter:
  - credit_return increments it, saturating at OUT_CREDITS.
  - Simultaneous consume and return leaves it unchanged.
- cfg_cin_groups=1: every issue is a last group. cfg_cout=1, width=height=1 are legal.
- start while busy: ignored.
- rst mid-layer: all state returns to reset values next cycle. Results still in the PE pipeline are discarded; the PE shares rst.

Test Plan:
- w=h=1, cout=1, groups=4, win_avail=1, credits ample -> wt_addr 0,1,2,3 on consecutive cycles; pe_last_channel only on 4th; 1 win_consume; done after the pe_data_valid with tag (0,0,0).
- w=2,h=1, cout=3, groups=2 -> 12 issues; wt_addr 0..5 repeated per pixel; win_consume after 6th and 12th issue; 6 result tags in order (0,0,0..2),(0,1,0..2).
- OUT_CREDITS=2, no credit_return, cout=4, groups=1 -> exactly 2 issues then stall; one credit_return -> exactly one more issue next cycle.
- win_avail held low 5 cycles at the second pixel -> no issue and no pe_valid_in during stall; resume cleanly when win_avail rises.
- RD_LAT=3 -> pe_valid_in appears exactly 3 cycles after the matching wt_addr change.
- Assert rst mid-RUN, then start a new layer -> outputs at reset values; new layer's first wt_addr=0; no stale tags output.
